// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Registers the decode control word and operands, inserts bubbles on
// load-use hazards and taken control transfers, drives EX forwarding
// selects, and keeps a saturating bubble counter.
module id_ex_stage #(
  parameter int DATA_WIDTH        = 32,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int ALU_Control_width = 3,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         RegWriteD,
  input  logic                         MemtoRegD,
  input  logic                         MemWriteD,
  input  logic [ALU_Control_width-1:0] ALUControlD,
  input  logic                         ALUSrcD,
  input  logic                         RegDstD,
  input  logic                         FlushReqD,
  input  logic [REG_ADDR_WIDTH-1:0]    RsD,
  input  logic [REG_ADDR_WIDTH-1:0]    RtD,
  input  logic [REG_ADDR_WIDTH-1:0]    RdD,
  input  logic [DATA_WIDTH-1:0]        RD1D,
  input  logic [DATA_WIDTH-1:0]        RD2D,
  input  logic [DATA_WIDTH-1:0]        SignImmD,
  input  logic [REG_ADDR_WIDTH-1:0]    WriteRegM,
  input  logic [REG_ADDR_WIDTH-1:0]    WriteRegW,
  input  logic                         RegWriteM,
  input  logic                         RegWriteW,
  output logic                         RegWriteE,
  output logic                         MemtoRegE,
  output logic                         MemWriteE,
  output logic                         ALUSrcE,
  output logic [ALU_Control_width-1:0] ALUControlE,
  output logic [REG_ADDR_WIDTH-1:0]    RsE,
  output logic [REG_ADDR_WIDTH-1:0]    RtE,
  output logic [DATA_WIDTH-1:0]        RD1E,
  output logic [DATA_WIDTH-1:0]        RD2E,
  output logic [DATA_WIDTH-1:0]        SignImmE,
  output logic [REG_ADDR_WIDTH-1:0]    WriteRegE,
  output logic                         ValidE,
  output logic                         StallF,
  output logic                         StallD,
  output logic [1:0]                   ForwardAE,
  output logic [1:0]                   ForwardBE,
  output logic [CNT_WIDTH-1:0]         BubbleCount
);

  logic                         r_reg_write;
  logic                         r_memto_reg;
  logic                         r_mem_write;
  logic                         r_alu_src;
  logic                         r_reg_dst;
  logic [ALU_Control_width-1:0] r_alu_ctrl;
  logic [REG_ADDR_WIDTH-1:0]    r_rs;
  logic [REG_ADDR_WIDTH-1:0]    r_rt;
  logic [REG_ADDR_WIDTH-1:0]    r_rd;
  logic [DATA_WIDTH-1:0]        r_rd1;
  logic [DATA_WIDTH-1:0]        r_rd2;
  logic [DATA_WIDTH-1:0]        r_imm;
  logic                         r_valid;
  logic [CNT_WIDTH-1:0]         r_bubble_cnt;

  logic w_load_use;
  logic w_bubble;
  logic w_cnt_full;

  // Load-use detection against the instruction currently in EX; register 0 never hazards.
  always_comb begin
    w_load_use = r_valid & r_memto_reg & r_reg_write & (r_rt != '0) &
                 ((r_rt == RsD) | (r_rt == RtD));
    w_bubble   = w_load_use | FlushReqD;
    w_cnt_full = &r_bubble_cnt;
  end

  // Pipeline register: bubbles load constant zeros so nothing from the D side leaks through.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_reg_write <= 1'b0;
      r_memto_reg <= 1'b0;
      r_mem_write <= 1'b0;
      r_alu_src   <= 1'b0;
      r_reg_dst   <= 1'b0;
      r_alu_ctrl  <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_imm       <= '0;
      r_valid     <= 1'b0;
    end else if (w_bubble) begin
      r_reg_write <= 1'b0;
      r_memto_reg <= 1'b0;
      r_mem_write <= 1'b0;
      r_alu_src   <= 1'b0;
      r_reg_dst   <= 1'b0;
      r_alu_ctrl  <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_imm       <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_reg_write <= RegWriteD;
      r_memto_reg <= MemtoRegD;
      r_mem_write <= MemWriteD;
      r_alu_src   <= ALUSrcD;
      r_reg_dst   <= RegDstD;
      r_alu_ctrl  <= ALUControlD;
      r_rs        <= RsD;
      r_rt        <= RtD;
      r_rd        <= RdD;
      r_rd1       <= RD1D;
      r_rd2       <= RD2D;
      r_imm       <= SignImmD;
      r_valid     <= 1'b1;
    end
  end

  // Saturating bubble counter; a coincident load-use and flush counts once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && !w_cnt_full) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  // Forwarding selects: MEM result has priority over WB; register 0 is never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if ((r_rs != '0) && RegWriteM && (WriteRegM == r_rs)) begin
      ForwardAE = 2'b10;
    end else if ((r_rs != '0) && RegWriteW && (WriteRegW == r_rs)) begin
      ForwardAE = 2'b01;
    end
    if ((r_rt != '0) && RegWriteM && (WriteRegM == r_rt)) begin
      ForwardBE = 2'b10;
    end else if ((r_rt != '0) && RegWriteW && (WriteRegW == r_rt)) begin
      ForwardBE = 2'b01;
    end
  end

  // Output mapping and stall outputs.
  always_comb begin
    RegWriteE   = r_reg_write;
    MemtoRegE   = r_memto_reg;
    MemWriteE   = r_mem_write;
    ALUSrcE     = r_alu_src;
    ALUControlE = r_alu_ctrl;
    RsE         = r_rs;
    RtE         = r_rt;
    RD1E        = r_rd1;
    RD2E        = r_rd2;
    SignImmE    = r_imm;
    WriteRegE   = r_reg_dst ? r_rd : r_rt;
    ValidE      = r_valid;
    StallF      = w_load_use;
    StallD      = w_load_use;
    BubbleCount = r_bubble_cnt;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load, load-use stall, flush,
// forwarding priority, async reset and counter saturation.
module tb_id_ex_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, FlushReqD;
  logic [2:0]  ALUControlD;
  logic [4:0]  RsD, RtD, RdD, WriteRegM, WriteRegW;
  logic [31:0] RD1D, RD2D, SignImmD;
  logic        RegWriteM, RegWriteW;
  logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, ValidE, StallF, StallD;
  logic [2:0]  ALUControlE;
  logic [4:0]  RsE, RtE, WriteRegE;
  logic [31:0] RD1E, RD2E, SignImmE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] BubbleCount;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage dut (
    .CLK(CLK), .RST(RST),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
    .FlushReqD(FlushReqD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
    .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .RsE(RsE), .RtE(RtE),
    .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .WriteRegE(WriteRegE),
    .ValidE(ValidE), .StallF(StallF), .StallD(StallD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .BubbleCount(BubbleCount)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_word(input logic rw, input logic m2r, input logic mw,
                            input logic src, input logic dst,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] a, input logic [31:0] b);
    RegWriteD = rw; MemtoRegD = m2r; MemWriteD = mw; ALUSrcD = src; RegDstD = dst;
    ALUControlD = 3'b010;
    RsD = rs; RtD = rt; RdD = rd; RD1D = a; RD2D = b; SignImmD = 32'h0000_0010;
  endtask

  initial begin
    RST = 1'b0; FlushReqD = 1'b0;
    drive_word(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    WriteRegM = 5'd0; WriteRegW = 5'd0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    #1;
    check("rst_ValidE", ValidE, 0);
    check("rst_RegWriteE", RegWriteE, 0);
    check("rst_WriteRegE", WriteRegE, 0);
    check("rst_BubbleCount", BubbleCount, 0);
    check("rst_StallD", StallD, 0);
    check("rst_ForwardAE", ForwardAE, 0);
    #11;
    RST = 1'b1;

    // add r3, r1, r2
    drive_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    tick();
    check("add_RegWriteE", RegWriteE, 1);
    check("add_WriteRegE", WriteRegE, 3);
    check("add_RD1E", RD1E, 5);
    check("add_RD2E", RD2E, 7);
    check("add_ALUControlE", ALUControlE, 3'b010);
    check("add_ValidE", ValidE, 1);
    check("add_BubbleCount", BubbleCount, 0);
    check("add_StallF", StallF, 0);

    // lw r8 into EX, then a consumer of r8 in decode
    drive_word(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd8, 5'd0, 32'd100, 32'd0);
    tick();
    check("lw_WriteRegE", WriteRegE, 8);
    drive_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd9, 5'd10, 32'd11, 32'd12);
    #1;
    check("lu_StallF", StallF, 1);
    check("lu_StallD", StallD, 1);
    tick();
    check("lu_ValidE", ValidE, 0);
    check("lu_RegWriteE", RegWriteE, 0);
    check("lu_MemtoRegE", MemtoRegE, 0);
    check("lu_ALUSrcE", ALUSrcE, 0);
    check("lu_RD1E", RD1E, 0);
    check("lu_RtE", RtE, 0);
    check("lu_BubbleCount", BubbleCount, 1);
    check("lu_StallD_after", StallD, 0);
    tick();
    check("lu_replay_ValidE", ValidE, 1);
    check("lu_replay_WriteRegE", WriteRegE, 10);
    check("lu_replay_BubbleCount", BubbleCount, 1);

    // flush with a valid store-type word
    drive_word(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 5'd3, 5'd4, 32'd1, 32'd2);
    FlushReqD = 1'b1;
    tick();
    FlushReqD = 1'b0;
    check("fl_RegWriteE", RegWriteE, 0);
    check("fl_MemWriteE", MemWriteE, 0);
    check("fl_ValidE", ValidE, 0);
    check("fl_BubbleCount", BubbleCount, 2);

    // load-use and flush together count once
    drive_word(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd8, 5'd0, 32'd100, 32'd0);
    tick();
    drive_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd9, 5'd10, 32'd11, 32'd12);
    FlushReqD = 1'b1;
    #1;
    check("both_StallD", StallD, 1);
    tick();
    FlushReqD = 1'b0;
    check("both_BubbleCount", BubbleCount, 3);
    check("both_ValidE", ValidE, 0);

    // forwarding priority with RsE=RtE=4
    drive_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd5, 32'd1, 32'd1);
    tick();
    WriteRegM = 5'd4; RegWriteM = 1'b1; WriteRegW = 5'd4; RegWriteW = 1'b1;
    #1;
    check("fwd_mem_A", ForwardAE, 2'b10);
    check("fwd_mem_B", ForwardBE, 2'b10);
    RegWriteM = 1'b0;
    #1;
    check("fwd_wb_A", ForwardAE, 2'b01);
    check("fwd_wb_B", ForwardBE, 2'b01);
    RegWriteW = 1'b0;
    #1;
    check("fwd_none_A", ForwardAE, 2'b00);
    RegWriteM = 1'b1; WriteRegW = 5'd7; RegWriteW = 1'b1;
    #1;
    check("fwd_memonly_B", ForwardBE, 2'b10);
    WriteRegM = 5'd6;
    #1;
    check("fwd_nomatch_A", ForwardAE, 2'b00);
    drive_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'd1, 32'd1);
    WriteRegM = 5'd0; RegWriteM = 1'b0; RegWriteW = 1'b0; WriteRegW = 5'd0;
    tick();
    RegWriteM = 1'b1; RegWriteW = 1'b1;
    #1;
    check("fwd_r0_A", ForwardAE, 2'b00);
    check("fwd_r0_B", ForwardBE, 2'b00);
    RegWriteM = 1'b0; RegWriteW = 1'b0;

    // async reset between edges
    drive_word(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    tick();
    check("ar_pre_ValidE", ValidE, 1);
    #2;
    RST = 1'b0;
    #1;
    check("ar_ValidE", ValidE, 0);
    check("ar_RegWriteE", RegWriteE, 0);
    check("ar_MemWriteE", MemWriteE, 0);
    check("ar_RD1E", RD1E, 0);
    check("ar_WriteRegE", WriteRegE, 0);
    check("ar_BubbleCount", BubbleCount, 0);
    #1;
    RST = 1'b1;
    tick();
    check("ar_release_ValidE", ValidE, 1);
    check("ar_release_WriteRegE", WriteRegE, 3);
    check("ar_release_BubbleCount", BubbleCount, 0);

    // saturation of the bubble counter
    FlushReqD = 1'b1;
    repeat (65534) @(posedge CLK);
    #1;
    check("sat_near", BubbleCount, 16'hFFFE);
    repeat (6) @(posedge CLK);
    #1;
    check("sat_hold", BubbleCount, 16'hFFFF);
    check("sat_ValidE", ValidE, 0);
    FlushReqD = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode-to-execute pipeline stage of the 5-stage MIPS core. It registers the decoder's control word (RegWrite, MemtoReg, MemWrite, ALUControl, ALUSrc, RegDst) together with the register operands, register specifiers and sign-extended immediate. It detects load-use hazards and inserts bubbles on those hazards and on taken control transfers. It also generates the EX-stage forwarding selects and keeps a saturating bubble counter for performance analysis.

Parameters:
DATA_WIDTH, 32, operand and immediate width
REG_ADDR_WIDTH, 5, register specifier width
ALU_Control_width, 3, ALUControl width
CNT_WIDTH, 16, bubble counter width

Ports:
CLK  in  1  clock, rising-edge
RST  in  1  asynchronous active-low reset
RegWriteD  in  1  decoder control
MemtoRegD  in  1  decoder control
MemWriteD  in  1  decoder control
ALUControlD  in  ALU_Control_width  decoder control
ALUSrcD  in  1  decoder control
RegDstD  in  1  decoder control
FlushReqD  in  1  taken branch or jump resolved in decode; squash the next EX entry
RsD, RtD, RdD  in  REG_ADDR_WIDTH  decode register specifiers
RD1D, RD2D  in  DATA_WIDTH  register file read data
SignImmD  in  DATA_WIDTH  sign-extended immediate
WriteRegM, WriteRegW  in  REG_ADDR_WIDTH  destination registers of MEM and WB
RegWriteM, RegWriteW  in  1  write enables of MEM and WB
RegWriteE, MemtoRegE, MemWriteE, ALUSrcE  out  1  registered controls
ALUControlE  out  ALU_Control_width  registered ALU control
RsE, RtE  out  REG_ADDR_WIDTH  registered specifiers
RD1E, RD2E, SignImmE  out  DATA_WIDTH  registered data
WriteRegE  out  REG_ADDR_WIDTH  comb: RegDstE ? RdE : RtE
ValidE  out  1  EX holds a real instruction
StallF, StallD  out  1  comb: hold PC and the IF/ID register
ForwardAE, ForwardBE  out  2  comb forwarding selects
BubbleCount  out  CNT_WIDTH  saturating count of bubble cycles

Behaviour:
- Reset: while RST=0, every registered output (all *E, RegDstE, RdE, ValidE, BubbleCount) goes to 0 asynchronously. Consequences: WriteRegE=0, StallF/StallD=0, ForwardAE/BE=00.
- Load-use hazard, combinational: LU = ValidE & MemtoRegE & RegWriteE & (RtE!=0) & (RtE==RsD | RtE==RtD).
- StallF = StallD = LU.
- Bubble = LU | FlushReqD.
- Each rising edge with RST=1:
  - If Bubble=1: RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE and ValidE load 0. The data and specifier registers load 0 as well, so a bubble never matches a forwarding compare or a hazard compare.
  - Otherwise: every E register loads its D input and ValidE loads 1.
- Latency: 1 cycle, D to E. No enable input; the stage always advances. A stall is realised by IF/ID holding its contents while this stage takes a bubble.
- LU and FlushReqD in the same cycle: a single bubble is inserted and BubbleCount increments by 1, not 2.
- Load followed by a dependent load: the hazard is detected against the first load only. After the bubble, ValidE=0, so LU deasserts and the stall lasts exactly 1 cycle.
- Register 0 is never a hazard source and never a forwarding source.
- ForwardAE:
  - 10 if RsE!=0 & RegWriteM & WriteRegM==RsE.
  - else 01 if RsE!=0 & RegWriteW & WriteRegW==RsE.
  - else 00.
  - MEM has priority over WB.
- ForwardBE: same rule using RtE.
- BubbleCount: +1 on each edge where Bubble=1. It saturates at 2^CNT_WIDTH-1 with no wrap.
- Reset asserted mid-operation: all E state clears immediately. The first edge after release loads the D inputs normally, unless Bubble=1 on that edge.
- No X may propagate from the *D inputs during a bubble. The bubble path uses constant zeros.

Test Plan:
- Reset/load: RST=0, then release. Drive the add-type word (RegWriteD=1, RegDstD=1, ALUControlD=010, RsD=1, RtD=2, RdD=3, RD1D=5, RD2D=7). One edge later: RegWriteE=1, WriteRegE=3, RD1E=5, ValidE=1, BubbleCount=0.
- Load-use: EX holds a load with RtE=8 (MemtoRegE=RegWriteE=1). Decode has RsD=8. Required: StallF=StallD=1 that cycle. Next edge: ValidE=0, all controls 0, BubbleCount=1. The following cycle: StallD=0.
- Flush: FlushReqD=1 with a valid D word. Next edge: bubble, RegWriteE=0, MemWriteE=0, BubbleCount increments by 1. Simultaneous LU and FlushReqD: BubbleCount still increments by exactly 1.
- Forwarding priority: RsE=4, RtE=4, WriteRegM=4, RegWriteM=1, WriteRegW=4, RegWriteW=1 gives ForwardAE=ForwardBE=10. With RegWriteM=0: 01. With RsE=0 and a match on 0: 00.
- Saturation: drive Bubble=1 for 65540 cycles. BubbleCount holds at 0xFFFF.
- Async reset mid-stream: assert RST=0 between clock edges while ValidE=1. All E outputs go to 0 before the next edge.
